// File: rtl/apb_arbiter.sv
// rtl/apb_arbiter.sv - two-master APB arbiter with round-robin grant and access watchdog
// Registered slave-side sequencing; master completions are combinational from the slave.
module apb_arbiter #(
  parameter int APB_paddr_WIDTH = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int TIMEOUT         = 255
) (
  input  logic                       clk,
  input  logic                       rts,
  input  logic [APB_paddr_WIDTH-1:0] m0_paddr,
  input  logic [DATA_WIDTH-1:0]      m0_pdata,
  input  logic                       m0_pwrite,
  input  logic [3:0]                 m0_pstb,
  input  logic                       m0_psel,
  input  logic                       m0_penable,
  output logic [DATA_WIDTH-1:0]      m0_prdata,
  output logic                       m0_pready,
  output logic                       m0_perr,
  input  logic [APB_paddr_WIDTH-1:0] m1_paddr,
  input  logic [DATA_WIDTH-1:0]      m1_pdata,
  input  logic                       m1_pwrite,
  input  logic [3:0]                 m1_pstb,
  input  logic                       m1_psel,
  input  logic                       m1_penable,
  output logic [DATA_WIDTH-1:0]      m1_prdata,
  output logic                       m1_pready,
  output logic                       m1_perr,
  output logic [APB_paddr_WIDTH-1:0] APB_paddr,
  output logic [DATA_WIDTH-1:0]      APB_pdata,
  output logic                       APB_pwrite,
  output logic [3:0]                 APB_pstb,
  output logic                       APB_psel,
  output logic                       APB_penable,
  input  logic [DATA_WIDTH-1:0]      APB_prdata,
  input  logic                       APB_pready,
  input  logic                       APB_perr,
  output logic                       owner
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LP_TMAX = TIMEOUT[CW-1:0];
  localparam bit LP_WD_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS} state_t;

  state_t                       r_state;
  logic                         r_last;
  logic                         r_owner;
  logic [CW-1:0]                r_cnt;
  logic [APB_paddr_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]        r_pdata;
  logic                         r_pwrite;
  logic [3:0]                   r_pstb;
  logic                         r_psel;
  logic                         r_penable;

  logic                         w_access;
  logic                         w_to;
  logic                         w_done;
  logic                         w_idle_gnt;
  logic                         w_gnt;
  logic                         w_other_req;
  logic                         w_m0_hit;
  logic                         w_m1_hit;
  logic [APB_paddr_WIDTH-1:0]   w_gnt_paddr;
  logic [DATA_WIDTH-1:0]        w_gnt_pdata;
  logic                         w_gnt_pwrite;
  logic [3:0]                   w_gnt_pstb;

  assign w_access = (r_state == S_ACCESS);
  // Slave ready always wins over an expiring watchdog in the same cycle.
  assign w_to     = LP_WD_EN && w_access && !APB_pready && (r_cnt == LP_TMAX);
  assign w_done   = w_access && (APB_pready || w_to);

  assign w_idle_gnt  = (m0_psel && m1_psel) ? ~r_last : m1_psel;
  assign w_gnt       = (r_state == S_IDLE) ? w_idle_gnt : ~r_owner;
  assign w_other_req = r_owner ? m0_psel : m1_psel;

  assign w_gnt_paddr  = w_gnt ? m1_paddr  : m0_paddr;
  assign w_gnt_pdata  = w_gnt ? m1_pdata  : m0_pdata;
  assign w_gnt_pwrite = w_gnt ? m1_pwrite : m0_pwrite;
  assign w_gnt_pstb   = w_gnt ? m1_pstb   : m0_pstb;

  // A master that dropped psel after grant gets no completion; reset suppresses it too.
  assign w_m0_hit = w_done && !r_owner && m0_psel && m0_penable && !rts;
  assign w_m1_hit = w_done &&  r_owner && m1_psel && m1_penable && !rts;

  assign m0_pready = w_m0_hit;
  assign m0_perr   = w_m0_hit && (w_to || APB_perr);
  assign m0_prdata = (w_m0_hit && !w_to) ? APB_prdata : '0;
  assign m1_pready = w_m1_hit;
  assign m1_perr   = w_m1_hit && (w_to || APB_perr);
  assign m1_prdata = (w_m1_hit && !w_to) ? APB_prdata : '0;

  assign APB_paddr   = r_paddr;
  assign APB_pdata   = r_pdata;
  assign APB_pwrite  = r_pwrite;
  assign APB_pstb    = r_pstb;
  assign APB_psel    = r_psel;
  assign APB_penable = r_penable;
  assign owner       = r_owner;

  always_ff @(posedge clk) begin
    if (rts) begin
      r_state   <= S_IDLE;
      r_last    <= 1'b1;
      r_owner   <= 1'b0;
      r_cnt     <= '0;
      r_paddr   <= '0;
      r_pdata   <= '0;
      r_pwrite  <= 1'b0;
      r_pstb    <= 4'b0000;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (m0_psel || m1_psel) begin
            r_paddr   <= w_gnt_paddr;
            r_pdata   <= w_gnt_pdata;
            r_pwrite  <= w_gnt_pwrite;
            r_pstb    <= w_gnt_pstb;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_owner   <= w_gnt;
            r_state   <= S_SETUP;
          end
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= S_ACCESS;
        end
        S_ACCESS: begin
          if (w_done) begin
            r_last <= r_owner;
            // Hand the bus straight to a waiting peer; the finisher cannot win again here.
            if (w_other_req) begin
              r_paddr   <= w_gnt_paddr;
              r_pdata   <= w_gnt_pdata;
              r_pwrite  <= w_gnt_pwrite;
              r_pstb    <= w_gnt_pstb;
              r_penable <= 1'b0;
              r_owner   <= w_gnt;
              r_state   <= S_SETUP;
            end else begin
              r_psel    <= 1'b0;
              r_penable <= 1'b0;
              r_state   <= S_IDLE;
            end
          end else if (r_cnt != LP_TMAX) begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_state   <= S_IDLE;
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb/tb_apb_arbiter.sv - self-checking bench for apb_arbiter with a transaction-level schedule model
module tb_apb_arbiter;

  localparam int TO = 4;
  localparam logic [31:0] K = 32'h5EAD_BEEF;

  logic        clk = 1'b0;
  logic        rts;
  logic [31:0] m0_paddr, m0_pdata, m1_paddr, m1_pdata;
  logic        m0_pwrite, m0_psel, m0_penable, m1_pwrite, m1_psel, m1_penable;
  logic [3:0]  m0_pstb, m1_pstb;
  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pready, m0_perr, m1_pready, m1_perr;
  logic [31:0] APB_paddr, APB_pdata, APB_prdata;
  logic        APB_pwrite, APB_psel, APB_penable, APB_pready, APB_perr;
  logic [3:0]  APB_pstb;
  logic        owner;

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  bit model_last;

  logic [31:0] t_addr [2][8];
  logic [31:0] t_data [2][8];
  logic        t_wr   [2][8];
  logic [3:0]  t_stb  [2][8];
  int          t_exp  [2][8];

  apb_arbiter #(.APB_paddr_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .clk(clk), .rts(rts),
    .m0_paddr(m0_paddr), .m0_pdata(m0_pdata), .m0_pwrite(m0_pwrite), .m0_pstb(m0_pstb),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_prdata(m0_prdata), .m0_pready(m0_pready),
    .m0_perr(m0_perr),
    .m1_paddr(m1_paddr), .m1_pdata(m1_pdata), .m1_pwrite(m1_pwrite), .m1_pstb(m1_pstb),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_prdata(m1_prdata), .m1_pready(m1_pready),
    .m1_perr(m1_perr),
    .APB_paddr(APB_paddr), .APB_pdata(APB_pdata), .APB_pwrite(APB_pwrite), .APB_pstb(APB_pstb),
    .APB_psel(APB_psel), .APB_penable(APB_penable), .APB_prdata(APB_prdata),
    .APB_pready(APB_pready), .APB_perr(APB_perr), .owner(owner)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave: wait states = paddr[2:0] (7 = never ready), rdata = paddr ^ K, perr = paddr[3].
  logic [2:0] sw_cnt = 3'd0;
  always @(posedge clk) begin
    if (rts || !(APB_psel && APB_penable) || APB_pready) sw_cnt <= 3'd0;
    else if (sw_cnt != 3'd7) sw_cnt <= sw_cnt + 3'd1;
  end
  assign APB_pready = APB_psel && APB_penable && (sw_cnt == APB_paddr[2:0]) && (APB_paddr[2:0] != 3'd7);
  assign APB_prdata = APB_paddr ^ K;
  assign APB_perr   = APB_paddr[3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic int eff_w(input logic [31:0] a);
    int w;
    w = int'(a[2:0]);
    return (w > TO) ? TO : w;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? m0_pready : m1_pready;
  endfunction

  task automatic set_bus(input int id, input logic sel, input logic en, input int k);
    if (id == 0) begin
      m0_psel = sel; m0_penable = en;
      if (k >= 0) begin
        m0_paddr = t_addr[0][k]; m0_pdata = t_data[0][k]; m0_pwrite = t_wr[0][k]; m0_pstb = t_stb[0][k];
      end
    end else begin
      m1_psel = sel; m1_penable = en;
      if (k >= 0) begin
        m1_paddr = t_addr[1][k]; m1_pdata = t_data[1][k]; m1_pwrite = t_wr[1][k]; m1_pstb = t_stb[1][k];
      end
    end
  endtask

  task automatic gen_txn(input int id, input int k, input int want);
    t_addr[id][k] = {$urandom} & 32'hFFFF_FFF8 | 32'(want);
    t_data[id][k] = $urandom;
    t_wr[id][k]   = 1'($urandom_range(0, 1));
    t_stb[id][k]  = 4'($urandom_range(0, 15));
  endtask

  // Expected completion offsets: the first grant goes to the sole requester or to the master
  // not served last; afterwards a waiting peer is served next. A transfer completes
  // 2 + waits cycles after the previous one, plus one idle cycle when the same master follows itself.
  task automatic plan(input int n0, input int n1);
    int rem[2];
    int idx[2];
    int prev, t, m;
    rem[0] = n0; rem[1] = n1; idx[0] = 0; idx[1] = 0; prev = -1; t = 0;
    while (rem[0] + rem[1] > 0) begin
      if (prev < 0) m = (rem[0] > 0 && rem[1] > 0) ? (model_last ? 0 : 1) : ((rem[0] > 0) ? 0 : 1);
      else m = (rem[1-prev] > 0) ? 1 - prev : prev;
      if (prev < 0) t = 2 + eff_w(t_addr[m][idx[m]]);
      else t = t + 2 + eff_w(t_addr[m][idx[m]]) + ((m == prev) ? 1 : 0);
      t_exp[m][idx[m]] = t;
      idx[m]++; rem[m]--; prev = m;
    end
    if (prev >= 0) model_last = (prev == 1);
  endtask

  task automatic run_master(input int id, input int n, input int t0);
    for (int k = 0; k < n; k++) begin
      bit got;
      int done_at;
      logic [31:0] a;
      bit tmo;
      a = t_addr[id][k];
      tmo = (int'(a[2:0]) > TO);
      set_bus(id, 1'b1, 1'b0, k);
      @(negedge clk);
      set_bus(id, 1'b1, 1'b1, -1);
      got = 0;
      done_at = 0;
      for (int c = 0; c < 60 && !got; c++) begin
        #3;
        if (rdy(id)) begin
          got = 1;
          done_at = cyc;
        end else @(negedge clk);
      end
      chk($sformatf("m%0d_t%0d_completed", id, k), 32'(got), 32'd1);
      if (got) begin
        chk($sformatf("m%0d_t%0d_cycle", id, k), 32'(done_at - t0), 32'(t_exp[id][k]));
        chk($sformatf("m%0d_t%0d_perr", id, k), 32'((id == 0) ? m0_perr : m1_perr),
            32'(tmo ? 1'b1 : a[3]));
        chk($sformatf("m%0d_t%0d_prdata", id, k), (id == 0) ? m0_prdata : m1_prdata,
            tmo ? 32'd0 : (a ^ K));
        chk($sformatf("m%0d_t%0d_paddr", id, k), APB_paddr, a);
        chk($sformatf("m%0d_t%0d_pstb", id, k), 32'(APB_pstb), 32'(t_stb[id][k]));
        chk($sformatf("m%0d_t%0d_pwrite", id, k), 32'(APB_pwrite), 32'(t_wr[id][k]));
        if (t_wr[id][k]) chk($sformatf("m%0d_t%0d_pdata", id, k), APB_pdata, t_data[id][k]);
        chk($sformatf("m%0d_t%0d_owner", id, k), 32'(owner), 32'(id));
        chk($sformatf("m%0d_t%0d_peer_quiet", id, k), 32'((id == 0) ? m1_pready : m0_pready), 32'd0);
      end
      @(negedge clk);
      if (k == n - 1) set_bus(id, 1'b0, 1'b0, -1);
    end
  endtask

  task automatic run_round(input int n0, input int n1);
    int t0;
    plan(n0, n1);
    @(negedge clk);
    t0 = cyc;
    fork
      run_master(0, n0, t0);
      run_master(1, n1, t0);
    join
    #3;
    chk("bus_released", 32'(APB_psel), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rts = 1'b1;
    set_bus(0, 1'b0, 1'b0, -1);
    set_bus(1, 1'b0, 1'b0, -1);
    repeat (2) @(negedge clk);
    rts = 1'b0;
    model_last = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit: observed expired expected finish");
    $fatal(1, "time limit");
  end

  initial begin
    rts = 1'b1;
    m0_paddr = '0; m0_pdata = '0; m0_pwrite = 0; m0_pstb = '0; m0_psel = 0; m0_penable = 0;
    m1_paddr = '0; m1_pdata = '0; m1_pwrite = 0; m1_pstb = '0; m1_psel = 0; m1_penable = 0;
    repeat (3) @(negedge clk);
    #3;
    chk("rst_psel", 32'(APB_psel), 32'd0);
    chk("rst_penable", 32'(APB_penable), 32'd0);
    chk("rst_pwrite", 32'(APB_pwrite), 32'd0);
    chk("rst_paddr", APB_paddr, 32'd0);
    chk("rst_pdata", APB_pdata, 32'd0);
    chk("rst_pstb", 32'(APB_pstb), 32'd0);
    chk("rst_owner", 32'(owner), 32'd0);
    chk("rst_m0_pready", 32'(m0_pready), 32'd0);
    chk("rst_m1_pready", 32'(m1_pready), 32'd0);
    @(negedge clk);
    rts = 1'b0;
    model_last = 1'b1;

    // Zero-wait read latency at slave and master.
    t_addr[0][0] = 32'h8000_0000; t_data[0][0] = '0; t_wr[0][0] = 1'b0; t_stb[0][0] = 4'hF;
    @(negedge clk);
    set_bus(0, 1'b1, 1'b0, 0);
    #3;
    chk("lat_T_psel", 32'(APB_psel), 32'd0);
    @(negedge clk);
    set_bus(0, 1'b1, 1'b1, -1);
    #3;
    chk("lat_T1_psel", 32'(APB_psel), 32'd1);
    chk("lat_T1_penable", 32'(APB_penable), 32'd0);
    chk("lat_T1_pready", 32'(m0_pready), 32'd0);
    @(negedge clk);
    #3;
    chk("lat_T2_penable", 32'(APB_penable), 32'd1);
    chk("lat_T2_pready", 32'(m0_pready), 32'd1);
    chk("lat_T2_prdata", m0_prdata, 32'hDEAD_BEEF);
    chk("lat_T2_perr", 32'(m0_perr), 32'd0);
    @(negedge clk);
    set_bus(0, 1'b0, 1'b0, -1);
    #3;
    chk("lat_T3_psel", 32'(APB_psel), 32'd0);
    model_last = 1'b0;
    repeat (2) @(negedge clk);

    // m1 write with three wait states.
    t_addr[1][0] = 32'h0000_2003; t_data[1][0] = 32'h1234_5678; t_wr[1][0] = 1'b1; t_stb[1][0] = 4'b0011;
    run_round(0, 1);

    // Slave never ready: watchdog completes with error.
    t_addr[0][0] = 32'h0000_0107; t_data[0][0] = '0; t_wr[0][0] = 1'b0; t_stb[0][0] = 4'hF;
    run_round(1, 0);

    // Simultaneous requests after reset: m0 first, m1 handed over without a gap.
    do_reset();
    gen_txn(0, 0, 1); gen_txn(1, 0, 0);
    run_round(1, 1);

    // Continuous contention: six alternating grants, wait states spanning the watchdog limit.
    for (int k = 0; k < 3; k++) begin
      gen_txn(0, k, $urandom_range(0, 5));
      gen_txn(1, k, $urandom_range(0, 5));
    end
    run_round(3, 3);

    for (int r = 0; r < 8; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      for (int k = 0; k < n0; k++) gen_txn(0, k, $urandom_range(0, 5));
      for (int k = 0; k < n1; k++) gen_txn(1, k, $urandom_range(0, 5));
      run_round(n0, n1);
    end

    // Reset while the slave is completing an ACCESS.
    do_reset();
    t_addr[0][0] = 32'h0000_0002; t_data[0][0] = '0; t_wr[0][0] = 1'b0; t_stb[0][0] = 4'hF;
    @(negedge clk);
    set_bus(0, 1'b1, 1'b0, 0);
    @(negedge clk);
    set_bus(0, 1'b1, 1'b1, -1);
    repeat (3) @(negedge clk);
    rts = 1'b1;
    #3;
    chk("rst_access_pready", 32'(m0_pready), 32'd0);
    @(negedge clk);
    rts = 1'b0;
    set_bus(0, 1'b0, 1'b0, -1);
    #3;
    chk("rst_access_psel", 32'(APB_psel), 32'd0);
    chk("rst_access_penable", 32'(APB_penable), 32'd0);
    chk("rst_access_owner", 32'(owner), 32'd0);
    chk("rst_access_m0_pready", 32'(m0_pready), 32'd0);
    model_last = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
